event_counter_bank: RTL and testbench

EVENT_COUNTER_BANK -- requirements
Module: event_counter_bank

---
 rtl/event_counter_bank_pkg.sv | 19 +
 rtl/event_counter_chan.sv | 150 +++++++++++++++
 rtl/event_counter_bank.sv | 63 ++++++
 tb/tb_event_counter_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/event_counter_bank_pkg.sv
// Shared types for the event counter bank: counting modes and the
// GATED-mode window state machine encoding.
package event_counter_bank_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LEVEL = 2'd0,
    MODE_EDGE  = 2'd1,
    MODE_CYCLE = 2'd2,
    MODE_GATED = 2'd3
  } mode_e;

  typedef enum logic {
    G_IDLE = 1'b0,
    G_RUN  = 1'b1
  } gstate_e;

endpackage

// File: rtl/event_counter_chan.sv
// One counter channel: event selection, GATED window FSM, counter with
// wrap/saturate, sticky overflow, threshold pulse and snapshot register.
module event_counter_chan
  import event_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = $clog2(NUM_EVENTS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] i_event,
  input  logic [NUM_EVENTS-1:0] i_event_prev,
  input  logic                  i_en,
  input  logic [SEL_W-1:0]      i_sel,
  input  logic [MODE_W-1:0]     i_mode,
  input  logic                  i_sat,
  input  logic                  i_clr,
  input  logic [CNT_W-1:0]      i_thresh,
  input  logic                  i_snap,
  output logic [CNT_W-1:0]      o_cnt,
  output logic [CNT_W-1:0]      o_snap,
  output logic                  o_ovf,
  output logic                  o_thr_irq
);

  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_snap;
  logic              r_ovf;
  logic              r_thr;
  logic [SEL_W-1:0]  r_sel_q;
  logic [MODE_W-1:0] r_mode_q;
  gstate_e           r_state;

  logic              w_ev;
  logic              w_ev_prev;
  logic              w_rise;
  mode_e             w_mode;
  logic              w_cfg_chg;
  gstate_e           w_state_eff;
  gstate_e           w_state_nxt;
  logic              w_gate_inc;
  logic              w_inc;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_ovf_nxt;
  logic              w_thr_nxt;

  assign w_mode    = mode_e'(i_mode);
  assign w_rise    = w_ev & ~w_ev_prev;
  // A select or mode change abandons any open GATED window.
  assign w_cfg_chg = (i_sel != r_sel_q) || (i_mode != r_mode_q);
  assign w_state_eff = w_cfg_chg ? G_IDLE : r_state;

  // Pick the selected event and its previous-cycle value; out-of-range
  // selects read as 0.
  always_comb begin
    w_ev      = 1'b0;
    w_ev_prev = 1'b0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (i_sel == SEL_W'(i)) begin
        w_ev      = i_event[i];
        w_ev_prev = i_event_prev[i];
      end
    end
  end

  // GATED window next state: open on a rising edge (counting that cycle),
  // close on the next rising edge, on enable drop, or on clear.
  always_comb begin
    w_state_nxt = G_IDLE;
    w_gate_inc  = 1'b0;
    if (w_mode == MODE_GATED && i_en) begin
      if (w_state_eff == G_IDLE) begin
        if (w_rise) begin
          w_state_nxt = G_RUN;
          w_gate_inc  = 1'b1;
        end
      end else if (!w_rise) begin
        w_state_nxt = G_RUN;
        w_gate_inc  = 1'b1;
      end
    end
    if (i_clr) begin
      w_state_nxt = G_IDLE;
    end
  end

  // GATED window state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= G_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Increment decision and next counter/overflow/threshold values; clear wins.
  always_comb begin
    w_inc = 1'b0;
    if (i_en) begin
      unique case (w_mode)
        MODE_LEVEL: w_inc = w_ev;
        MODE_EDGE:  w_inc = w_rise;
        MODE_CYCLE: w_inc = 1'b1;
        MODE_GATED: w_inc = w_gate_inc;
      endcase
    end
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    if (i_clr) begin
      w_cnt_nxt = '0;
      w_ovf_nxt = 1'b0;
    end else if (w_inc) begin
      if (&r_cnt) begin
        w_cnt_nxt = i_sat ? r_cnt : '0;
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
    w_thr_nxt = !i_clr && (w_cnt_nxt != r_cnt) && (w_cnt_nxt == i_thresh);
  end

  // Counter, flags, snapshot and previous-config registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt    <= '0;
      r_snap   <= '0;
      r_ovf    <= 1'b0;
      r_thr    <= 1'b0;
      r_sel_q  <= '0;
      r_mode_q <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_ovf    <= w_ovf_nxt;
      r_thr    <= w_thr_nxt;
      r_sel_q  <= i_sel;
      r_mode_q <= i_mode;
      if (i_snap) begin
        r_snap <= r_cnt;
      end
    end
  end

  assign o_cnt     = r_cnt;
  assign o_snap    = r_snap;
  assign o_ovf     = r_ovf;
  assign o_thr_irq = r_thr;

endmodule

// File: rtl/event_counter_bank.sv
// Bank of independent event counters sharing one set of event inputs.
// Edge history is kept once here and fanned out to every channel.
module event_counter_bank
  import event_counter_bank_pkg::*;
#(
  parameter int NUM_EVENTS = 8,
  parameter int NUM_CNT    = 4,
  parameter int CNT_W      = 32
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NUM_EVENTS-1:0]                 event_i,
  input  logic [NUM_CNT-1:0]                    en_i,
  input  logic [NUM_CNT*$clog2(NUM_EVENTS)-1:0] sel_i,
  input  logic [NUM_CNT*MODE_W-1:0]             mode_i,
  input  logic [NUM_CNT-1:0]                    sat_i,
  input  logic [NUM_CNT-1:0]                    clr_i,
  input  logic [NUM_CNT*CNT_W-1:0]              thresh_i,
  input  logic                                  snap_i,
  output logic [NUM_CNT*CNT_W-1:0]              cnt_o,
  output logic [NUM_CNT*CNT_W-1:0]              snap_o,
  output logic [NUM_CNT-1:0]                    ovf_o,
  output logic [NUM_CNT-1:0]                    thr_irq_o
);

  localparam int SEL_W = $clog2(NUM_EVENTS);

  logic [NUM_EVENTS-1:0] r_ev_prev;

  // Previous-cycle event history, updated every cycle regardless of enables.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ev_prev <= '0;
    end else begin
      r_ev_prev <= event_i;
    end
  end

  for (genvar c = 0; c < NUM_CNT; c++) begin : g_chan
    event_counter_chan #(
      .NUM_EVENTS (NUM_EVENTS),
      .CNT_W      (CNT_W),
      .SEL_W      (SEL_W)
    ) u_chan (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_event      (event_i),
      .i_event_prev (r_ev_prev),
      .i_en         (en_i[c]),
      .i_sel        (sel_i[c*SEL_W +: SEL_W]),
      .i_mode       (mode_i[c*MODE_W +: MODE_W]),
      .i_sat        (sat_i[c]),
      .i_clr        (clr_i[c]),
      .i_thresh     (thresh_i[c*CNT_W +: CNT_W]),
      .i_snap       (snap_i),
      .o_cnt        (cnt_o[c*CNT_W +: CNT_W]),
      .o_snap       (snap_o[c*CNT_W +: CNT_W]),
      .o_ovf        (ovf_o[c]),
      .o_thr_irq    (thr_irq_o[c])
    );
  end

endmodule

// File: tb/tb_event_counter_bank.sv
// Bench for event_counter_bank: directed scenarios followed by random
// traffic, all checked against a behavioural model of the counting rules.
module tb_event_counter_bank;
  import event_counter_bank_pkg::*;

  localparam int NUM_EVENTS = 8;
  localparam int NUM_CNT    = 4;
  localparam int CNT_W      = 4;
  localparam int SEL_W      = $clog2(NUM_EVENTS);
  localparam int MAXV       = (1 << CNT_W) - 1;

  logic                          clk = 1'b0;
  logic                          rst_ni = 1'b1;
  logic [NUM_EVENTS-1:0]         ev_v = '0;
  logic [NUM_CNT-1:0]            en = '0;
  logic [NUM_CNT*SEL_W-1:0]      sel = '0;
  logic [NUM_CNT*MODE_W-1:0]     mode = '0;
  logic [NUM_CNT-1:0]            sat = '0;
  logic [NUM_CNT-1:0]            clr = '0;
  logic [NUM_CNT*CNT_W-1:0]      thresh = '0;
  logic                          snap = 1'b0;
  logic [NUM_CNT*CNT_W-1:0]      cnt_o;
  logic [NUM_CNT*CNT_W-1:0]      snap_o;
  logic [NUM_CNT-1:0]            ovf_o;
  logic [NUM_CNT-1:0]            thr_irq_o;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state
  int unsigned           m_cnt  [NUM_CNT];
  int unsigned           m_snap [NUM_CNT];
  bit                    m_ovf  [NUM_CNT];
  bit                    m_thr  [NUM_CNT];
  bit                    m_win  [NUM_CNT];
  int                    m_psel [NUM_CNT];
  int                    m_pmode[NUM_CNT];
  logic [NUM_EVENTS-1:0] m_prev_ev;

  event_counter_bank #(
    .NUM_EVENTS (NUM_EVENTS),
    .NUM_CNT    (NUM_CNT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .event_i   (ev_v),
    .en_i      (en),
    .sel_i     (sel),
    .mode_i    (mode),
    .sat_i     (sat),
    .clr_i     (clr),
    .thresh_i  (thresh),
    .snap_i    (snap),
    .cnt_o     (cnt_o),
    .snap_o    (snap_o),
    .ovf_o     (ovf_o),
    .thr_irq_o (thr_irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] cnt_of(input int c);
    return 64'(cnt_o[c*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [63:0] snap_of(input int c);
    return 64'(snap_o[c*CNT_W +: CNT_W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NUM_CNT; c++) begin
      m_cnt[c] = 0; m_snap[c] = 0; m_ovf[c] = 0; m_thr[c] = 0;
      m_win[c] = 0; m_psel[c] = 0; m_pmode[c] = 0;
    end
    m_prev_ev = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_cnt"},  64'(cnt_o),     64'd0);
    check_eq({tag, "_snap"}, 64'(snap_o),    64'd0);
    check_eq({tag, "_ovf"},  64'(ovf_o),     64'd0);
    check_eq({tag, "_thr"},  64'(thr_irq_o), 64'd0);
  endtask

  // Apply current inputs for one clock, advance the model, compare outputs.
  task automatic step();
    for (int c = 0; c < NUM_CNT; c++) begin
      int          s;
      int          md;
      bit          cur, rise, inc;
      int unsigned nv;
      s    = int'(sel[c*SEL_W +: SEL_W]);
      md   = int'(mode[c*MODE_W +: MODE_W]);
      cur  = ev_v[s];
      rise = cur && !m_prev_ev[s];
      inc  = 0;
      if (s != m_psel[c] || md != m_pmode[c]) m_win[c] = 0;
      if (en[c]) begin
        case (md)
          0: inc = cur;
          1: inc = rise;
          2: inc = 1;
          default: begin
            if (!m_win[c]) begin
              inc = rise;
              m_win[c] = rise;
            end else if (rise) begin
              m_win[c] = 0;
            end else begin
              inc = 1;
            end
          end
        endcase
      end
      if (!en[c] || md != 3) m_win[c] = 0;
      if (snap) m_snap[c] = m_cnt[c];
      if (clr[c]) begin
        nv = 0; m_ovf[c] = 0; m_win[c] = 0;
      end else if (inc) begin
        if (m_cnt[c] == MAXV) begin
          nv = sat[c] ? MAXV : 0;
          m_ovf[c] = 1;
        end else begin
          nv = m_cnt[c] + 1;
        end
      end else begin
        nv = m_cnt[c];
      end
      m_thr[c]   = !clr[c] && (nv != m_cnt[c]) && (nv == int'(thresh[c*CNT_W +: CNT_W]));
      m_cnt[c]   = nv;
      m_psel[c]  = s;
      m_pmode[c] = md;
    end
    m_prev_ev = ev_v;
    @(posedge clk);
    #1;
    for (int c = 0; c < NUM_CNT; c++) begin
      check_eq($sformatf("cnt[%0d]", c),  cnt_of(c),            64'(m_cnt[c]));
      check_eq($sformatf("ovf[%0d]", c),  64'(ovf_o[c]),        64'(m_ovf[c]));
      check_eq($sformatf("thr[%0d]", c),  64'(thr_irq_o[c]),    64'(m_thr[c]));
      check_eq($sformatf("snap[%0d]", c), snap_of(c),           64'(m_snap[c]));
    end
  endtask

  task automatic cfg(input int c, input int s, input int md, input bit e, input bit st, input int th);
    sel[c*SEL_W +: SEL_W]    = s[SEL_W-1:0];
    mode[c*MODE_W +: MODE_W] = md[MODE_W-1:0];
    en[c]                    = e;
    sat[c]                   = st;
    thresh[c*CNT_W +: CNT_W] = th[CNT_W-1:0];
  endtask

  task automatic clear_all();
    ev_v = '0; en = '0; snap = 1'b0; clr = '1;
    step();
    clr = '0;
  endtask

  initial begin
    int pulses;
    int cnt_at_pulse;

    model_reset();
    #2 rst_ni = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_hold");
    rst_ni = 1'b1;

    // LEVEL, select 2, five high cycles
    clear_all();
    cfg(0, 2, MODE_LEVEL, 1, 0, 15);
    cfg(1, 3, MODE_LEVEL, 1, 0, 15);
    ev_v[2] = 1'b1;
    repeat (5) step();
    ev_v = '0;
    check_eq("level_cnt0", cnt_of(0), 64'd5);
    check_eq("level_cnt1", cnt_of(1), 64'd0);
    step();
    check_eq("level_hold", cnt_of(0), 64'd5);
    check_eq("level_cnt2", cnt_of(2), 64'd0);

    // EDGE vs LEVEL on four 3-cycle pulses
    clear_all();
    cfg(0, 1, MODE_EDGE, 1, 0, 15);
    cfg(1, 1, MODE_LEVEL, 1, 0, 15);
    for (int p = 0; p < 4; p++) begin
      ev_v[1] = 1'b1; repeat (3) step();
      ev_v[1] = 1'b0; repeat (2) step();
    end
    check_eq("edge_cnt", cnt_of(0), 64'd4);
    check_eq("edge_level_cnt", cnt_of(1), 64'd12);

    // CYCLE, 17 cycles, wrap vs saturate
    clear_all();
    cfg(2, 0, MODE_CYCLE, 1, 0, 0);
    cfg(3, 0, MODE_CYCLE, 1, 1, 0);
    repeat (17) step();
    check_eq("wrap_cnt", cnt_of(2), 64'd1);
    check_eq("wrap_ovf", 64'(ovf_o[2]), 64'd1);
    check_eq("sat_cnt", cnt_of(3), 64'd15);
    check_eq("sat_ovf", 64'(ovf_o[3]), 64'd1);

    // GATED, rising edges 10 cycles apart
    clear_all();
    cfg(0, 4, MODE_GATED, 1, 0, 15);
    step();
    ev_v[4] = 1'b1; step();
    ev_v[4] = 1'b0; repeat (9) step();
    ev_v[4] = 1'b1; step();
    check_eq("gated_cnt", cnt_of(0), 64'd10);
    ev_v[4] = 1'b0; repeat (3) step();
    check_eq("gated_idle", cnt_of(0), 64'd10);

    // GATED, enable dropped at cycle 4
    clear_all();
    cfg(1, 5, MODE_GATED, 1, 0, 15);
    step();
    ev_v[5] = 1'b1; step();
    ev_v[5] = 1'b0; repeat (3) step();
    en[1] = 1'b0; step();
    en[1] = 1'b1; repeat (4) step();
    check_eq("gated_en_drop", cnt_of(1), 64'd4);

    // Threshold 7 in CYCLE mode
    clear_all();
    cfg(0, 0, MODE_CYCLE, 1, 0, 7);
    pulses = 0;
    cnt_at_pulse = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (thr_irq_o[0]) begin
        pulses++;
        cnt_at_pulse = int'(cnt_of(0));
      end
    end
    check_eq("thr_pulses", 64'(pulses), 64'd1);
    check_eq("thr_at_cnt", 64'(cnt_at_pulse), 64'd7);

    // Clear beats increment at count 6
    clear_all();
    cfg(1, 0, MODE_CYCLE, 1, 0, 7);
    repeat (6) step();
    clr[1] = 1'b1; step(); clr[1] = 1'b0;
    check_eq("clr_cnt", cnt_of(1), 64'd0);
    check_eq("clr_thr", 64'(thr_irq_o[1]), 64'd0);

    // Snapshot coincident with clear at count 9
    clear_all();
    cfg(2, 0, MODE_CYCLE, 1, 0, 0);
    repeat (9) step();
    snap = 1'b1; clr[2] = 1'b1; step();
    snap = 1'b0; clr[2] = 1'b0;
    check_eq("snapclr_snap", snap_of(2), 64'd9);
    check_eq("snapclr_cnt", cnt_of(2), 64'd0);

    // Reset mid-count clears everything immediately
    repeat (3) step();
    rst_ni = 1'b0;
    #2 check_all_zero("midreset");
    #2 rst_ni = 1'b1;
    model_reset();
    step();
    check_eq("post_reset_cnt", cnt_of(2), 64'd1);

    // Random traffic
    for (int c = 0; c < NUM_CNT; c++)
      cfg(c, $urandom_range(0, NUM_EVENTS-1), $urandom_range(0, 3), 1, $urandom_range(0, 1), $urandom_range(0, MAXV));
    for (int i = 0; i < 800; i++) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        if ($urandom_range(0, 24) == 0)
          cfg(c, $urandom_range(0, NUM_EVENTS-1), $urandom_range(0, 3), 1, $urandom_range(0, 1), $urandom_range(0, MAXV));
        en[c]  = ($urandom_range(0, 7) != 0);
        clr[c] = ($urandom_range(0, 39) == 0);
      end
      ev_v = NUM_EVENTS'($urandom);
      snap = ($urandom_range(0, 14) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
